// File: rtl/on_chip_fsm_hpi_bus_master.sv
// Avalon-MM slave that turns each access into one timed CY7C67200 HPI read/write
// cycle. All pad-facing outputs are registered; the bidirectional data bus is split.
module on_chip_fsm_hpi_bus_master #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_hpi_addr,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE,
    S_RECOVER
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] REC_LD    = (RECOVERY_CYC == 0) ? 4'd0 : 4'(RECOVERY_CYC - 1);
  localparam bit         HAS_REC   = (RECOVERY_CYC != 0);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        dir_write;
  logic        acc_write;
  logic        active_next;
  logic        req;
  logic [15:0] rdata;

  // Upper half of the Avalon write word has no HPI meaning.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^writedata[31:16];

  assign req         = chipselect & (read | write);
  assign waitrequest = req & (state != S_DONE);
  assign readdata    = {16'b0, rdata};

  // Direction comes straight from the bus on the accept cycle, from the latch after.
  assign acc_write   = (state == S_IDLE) ? write : dir_write;
  assign active_next = (state_next == S_SETUP) || (state_next == S_STROBE) ||
                       (state_next == S_HOLD);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = S_SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt == 4'd0) begin
          state_next = S_STROBE;
          cnt_next   = STROBE_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt == 4'd0) begin
          state_next = S_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt == 4'd0) begin
          state_next = S_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (HAS_REC) begin
          state_next = S_RECOVER;
          cnt_next   = REC_LD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RECOVER: begin
        if (cnt == 4'd0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pins are computed from the next state so they switch exactly with the state register.
  // NOTE: reset is synchronous; it is just the highest-priority branch under the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      cnt              <= 4'd0;
      dir_write        <= 1'b0;
      rdata            <= 16'd0;
      otg_hpi_addr     <= 2'd0;
      otg_hpi_cs_n     <= 1'b1;
      otg_hpi_r_n      <= 1'b1;
      otg_hpi_w_n      <= 1'b1;
      otg_hpi_data_out <= 16'd0;
      otg_hpi_data_oe  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state           <= state_next;
      cnt             <= cnt_next;
      otg_hpi_cs_n    <= !active_next;
      otg_hpi_r_n     <= !((state_next == S_STROBE) && !acc_write);
      otg_hpi_w_n     <= !((state_next == S_STROBE) && acc_write);
      otg_hpi_data_oe <= active_next && acc_write;
      if ((state == S_IDLE) && req) begin
        dir_write    <= write;
        otg_hpi_addr <= address;
        if (write) begin
          otg_hpi_data_out <= writedata[15:0];
        end
      end
      if ((state == S_STROBE) && (cnt == 4'd0) && !dir_write) begin
        rdata <= otg_hpi_data_in;
      end
    end
  end

endmodule
